// File: rtl/tt_um_irrationalanalysis_prbs31_checker.sv
// tt_um_irrationalanalysis_prbs31_checker
// Byte-parallel PRBS31 (x^31 + x^28 + 1) receiver/checker. Seeds a local LFSR
// from the received stream, verifies it over a trial window, then counts bit
// errors in a saturating 16-bit counter while locked.
// Optional build macro: PRBS31_CHK_INVERT_EN -- when defined, uio_in[4]=1
// inverts every received byte before seeding and comparison.

module tt_um_irrationalanalysis_prbs31_checker (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        TRIAL  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Next 8 stream bits predicted from the LFSR state; bit 7 comes first.
    function automatic logic [7:0] pred_byte(input logic [30:0] s_in);
        logic [30:0] t;
        logic [7:0]  p;
        logic        b;
        t = s_in;
        p = '0;
        for (int i = 7; i >= 0; i--) begin
            b    = t[30] ^ t[27];
            p[i] = b;
            t    = {t[29:0], b};
        end
        return p;
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    // Add an error count, clamping at the top of the 16-bit range.
    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [3:0] e);
        logic [16:0] sum;
        sum = {1'b0, a} + {13'b0, e};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    state_t      state, state_nxt;
    logic [30:0] s, s_nxt;
    logic [2:0]  phase_cnt, phase_cnt_nxt;   // seed bytes in SEED, matches in TRIAL
    logic [1:0]  bad_cnt, bad_cnt_nxt;       // consecutive badly errored bytes in LOCKED
    logic [15:0] err_cnt, err_cnt_nxt;
    logic        lost, lost_nxt;
    logic        err_pulse, err_pulse_nxt;
    logic        cnt_sat, cnt_sat_nxt;

    logic        vld_p0;
    logic [7:0]  data_p0;
    logic [7:0]  pred_p0;
    logic [3:0]  errs_p0;
    logic [30:0] s_pred_p0;
    logic [30:0] s_seed_p0;
    logic        loss_p0;
    logic        clr_cnt;
    logic        relock;
    logic        byte_sel;
    logic        unused_ok;

    assign vld_p0   = ena & uio_in[0];
    assign clr_cnt  = uio_in[1];
    assign relock   = uio_in[2];
    assign byte_sel = uio_in[3];

`ifdef PRBS31_CHK_INVERT_EN
    assign data_p0   = ui_in ^ {8{uio_in[4]}};
    assign unused_ok = &{1'b0, uio_in[7:5]};
`else
    assign data_p0   = ui_in;
    assign unused_ok = &{1'b0, uio_in[7:4]};
`endif

    assign pred_p0   = pred_byte(s);
    assign errs_p0   = popcount8(pred_p0 ^ data_p0);
    assign s_pred_p0 = {s[22:0], pred_p0};
    assign s_seed_p0 = {s[22:0], data_p0};

    // Next-state and status update for one edge; relock and clr_cnt override last.
    always_comb begin
        state_nxt     = state;
        s_nxt         = s;
        phase_cnt_nxt = phase_cnt;
        bad_cnt_nxt   = bad_cnt;
        err_cnt_nxt   = err_cnt;
        lost_nxt      = lost;
        err_pulse_nxt = 1'b0;
        loss_p0       = 1'b0;

        if (vld_p0) begin
            case (state)
                SEED: begin
                    s_nxt = s_seed_p0;
                    if (phase_cnt == 3'd3) begin
                        if (s_seed_p0 != 31'd0) begin
                            state_nxt     = TRIAL;
                            phase_cnt_nxt = 3'd0;
                        end
                    end else begin
                        phase_cnt_nxt = phase_cnt + 3'd1;
                    end
                end
                TRIAL: begin
                    s_nxt = s_pred_p0;
                    if (errs_p0 == 4'd0) begin
                        if (phase_cnt == 3'd7) begin
                            state_nxt   = LOCKED;
                            bad_cnt_nxt = 2'd0;
                        end else begin
                            phase_cnt_nxt = phase_cnt + 3'd1;
                        end
                    end else begin
                        state_nxt     = SEED;
                        phase_cnt_nxt = 3'd0;
                    end
                end
                LOCKED: begin
                    s_nxt         = s_pred_p0;
                    err_cnt_nxt   = sat_add(err_cnt, errs_p0);
                    err_pulse_nxt = (errs_p0 != 4'd0);
                    if (errs_p0 >= 4'd2) begin
                        if (bad_cnt == 2'd3) begin
                            loss_p0       = 1'b1;
                            state_nxt     = SEED;
                            phase_cnt_nxt = 3'd0;
                            bad_cnt_nxt   = 2'd0;
                        end else begin
                            bad_cnt_nxt = bad_cnt + 2'd1;
                        end
                    end else begin
                        bad_cnt_nxt = 2'd0;
                    end
                end
                default: begin
                    state_nxt     = SEED;
                    phase_cnt_nxt = 3'd0;
                    bad_cnt_nxt   = 2'd0;
                end
            endcase
        end

        if (loss_p0) begin
            lost_nxt = 1'b1;
        end

        if (relock) begin
            state_nxt     = SEED;
            phase_cnt_nxt = 3'd0;
            bad_cnt_nxt   = 2'd0;
        end

        if (clr_cnt) begin
            err_cnt_nxt = 16'd0;
            lost_nxt    = 1'b0;
        end

        cnt_sat_nxt = (err_cnt_nxt == 16'hFFFF);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
        end else begin
            state <= state_nxt;
        end
    end

    // LFSR, counters and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s         <= 31'd0;
            phase_cnt <= 3'd0;
            bad_cnt   <= 2'd0;
            err_cnt   <= 16'd0;
            lost      <= 1'b0;
            err_pulse <= 1'b0;
            cnt_sat   <= 1'b0;
        end else begin
            s         <= s_nxt;
            phase_cnt <= phase_cnt_nxt;
            bad_cnt   <= bad_cnt_nxt;
            err_cnt   <= err_cnt_nxt;
            lost      <= lost_nxt;
            err_pulse <= err_pulse_nxt;
            cnt_sat   <= cnt_sat_nxt;
        end
    end

    assign uo_out  = byte_sel ? err_cnt[15:8] : err_cnt[7:0];
    assign uio_out = {cnt_sat, err_pulse, lost, (state == LOCKED), 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_irrationalanalysis_prbs31_checker.sv
// Self-checking bench for the PRBS31 checker. The reference model tracks the
// received stream as a queue of bits and applies the recurrence
// x[n] = x[n-31] ^ x[n-28] directly.

module tb_tt_um_irrationalanalysis_prbs31_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    always #5 clk = ~clk;

    tt_um_irrationalanalysis_prbs31_checker dut (
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe),
        .ena    (ena),
        .clk    (clk),
        .rst_n  (rst_n)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic drv_ena = 1'b1;
    logic inv     = 1'b0;
    logic bsel    = 1'b0;

    // Transmitter: history of the last 31 stream bits, oldest first.
    bit gen_q[$];

    // Reference checker model.
    bit m_hist[$];
    int m_mode;      // 0 seeding, 1 trial, 2 locked
    int m_cnt;
    int m_bad;
    int m_err;
    bit m_lost;
    bit m_pulse;
    bit m_sat;

    task automatic gen_reset();
        gen_q.delete();
        for (int i = 0; i < 31; i++) gen_q.push_back(1'b1);
    endtask

    task automatic gen_byte(output logic [7:0] b);
        bit nb;
        for (int i = 7; i >= 0; i--) begin
            nb   = gen_q[0] ^ gen_q[3];
            b[i] = nb;
            gen_q.push_back(nb);
            void'(gen_q.pop_front());
        end
    endtask

    task automatic m_reset();
        m_hist.delete();
        for (int i = 0; i < 31; i++) m_hist.push_back(1'b0);
        m_mode = 0; m_cnt = 0; m_bad = 0; m_err = 0;
        m_lost = 0; m_pulse = 0; m_sat = 0;
    endtask

    function automatic logic [7:0] m_predict();
        bit t[$];
        bit nb;
        logic [7:0] p;
        t = m_hist;
        for (int i = 7; i >= 0; i--) begin
            nb   = t[0] ^ t[3];
            p[i] = nb;
            t.push_back(nb);
            void'(t.pop_front());
        end
        return p;
    endfunction

    task automatic m_shift(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            m_hist.push_back(v[i]);
            void'(m_hist.pop_front());
        end
    endtask

    task automatic model_edge(input logic [7:0] b, input bit acc, input bit clr, input bit rl);
        logic [7:0] d;
        logic [7:0] p;
        int e;
        bit lol;
        bit nz;
        lol = 0;
        m_pulse = 0;
`ifdef PRBS31_CHK_INVERT_EN
        d = b ^ {8{inv}};
`else
        d = b;
`endif
        if (acc) begin
            p = m_predict();
            if (m_mode == 0) begin
                m_shift(d);
                m_cnt++;
                nz = 0;
                foreach (m_hist[k]) if (m_hist[k]) nz = 1;
                if (m_cnt >= 4 && nz) begin m_mode = 1; m_cnt = 0; end
            end else if (m_mode == 1) begin
                m_shift(p);
                if (p == d) begin
                    m_cnt++;
                    if (m_cnt == 8) begin m_mode = 2; m_bad = 0; end
                end else begin
                    m_mode = 0; m_cnt = 0;
                end
            end else begin
                m_shift(p);
                e = $countones(p ^ d);
                m_err = m_err + e;
                if (m_err > 65535) m_err = 65535;
                m_pulse = (e > 0);
                if (e >= 2) begin
                    m_bad++;
                    if (m_bad == 4) begin lol = 1; m_mode = 0; m_cnt = 0; m_bad = 0; end
                end else begin
                    m_bad = 0;
                end
            end
        end
        if (lol) m_lost = 1;
        if (rl) begin m_mode = 0; m_cnt = 0; m_bad = 0; end
        if (clr) begin m_err = 0; m_lost = 0; end
        m_sat = (m_err == 65535);
    endtask

    // Drive one clock cycle of stimulus; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic [7:0] b, input bit v, input bit clr, input bit rl);
        ui_in  = b;
        uio_in = {3'b000, inv, bsel, rl, clr, v};
        ena    = drv_ena;
        @(posedge clk);
        model_edge(b, drv_ena & v, clr, rl);
        #1;
        uio_in[2:0] = 3'b000;
    endtask

    task automatic read_cnt(output logic [15:0] c);
        uio_in[3] = 1'b0;
        #1 c[7:0] = uo_out;
        uio_in[3] = 1'b1;
        #1 c[15:8] = uo_out;
        uio_in[3] = bsel;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ena = 1'b0; ui_in = 8'h00; uio_in = 8'h00;
        drv_ena = 1'b1; inv = 1'b0; bsel = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        m_reset();
        gen_reset();
    endtask

    task automatic send_clean(input int n);
        logic [7:0] g;
        for (int i = 0; i < n; i++) begin
            gen_byte(g);
            step(g, 1, 0, 0);
        end
    endtask

    task automatic test_reset();
        #3;
        n_cmp++; if (uio_oe !== 8'hF0) begin n_bad++; $display("FAIL reset_oe: got %h want f0", uio_oe); end
        n_cmp++; if (uio_out !== 8'h00) begin n_bad++; $display("FAIL reset_uio_out: got %h want 00", uio_out); end
        uio_in = 8'h00; #1;
        n_cmp++; if (uo_out !== 8'h00) begin n_bad++; $display("FAIL reset_uo_lo: got %h want 00", uo_out); end
        uio_in = 8'h08; #1;
        n_cmp++; if (uo_out !== 8'h00) begin n_bad++; $display("FAIL reset_uo_hi: got %h want 00", uo_out); end
        do_reset();
    endtask

    task automatic test_clean_lock();
        logic [7:0]  g;
        logic [15:0] c;
        do_reset();
        for (int i = 1; i <= 64; i++) begin
            gen_byte(g);
            step(g, 1, 0, 0);
            n_cmp++; if (uio_out[4] !== (i >= 12)) begin n_bad++; $display("FAIL clean_locked byte %0d: got %b want %b", i, uio_out[4], (i >= 12)); end
            n_cmp++; if (uio_out[6] !== 1'b0) begin n_bad++; $display("FAIL clean_pulse byte %0d: got %b want 0", i, uio_out[6]); end
        end
        read_cnt(c);
        n_cmp++; if (c !== 16'h0000) begin n_bad++; $display("FAIL clean_cnt: got %h want 0000", c); end
    endtask

    task automatic test_single_error();
        logic [7:0] g;
        do_reset();
        send_clean(19);
        gen_byte(g);
        step(g ^ 8'h01, 1, 0, 0);
        n_cmp++; if (uio_out[6] !== 1'b1) begin n_bad++; $display("FAIL single_pulse_hi: got %b want 1", uio_out[6]); end
        n_cmp++; if (uio_out[4] !== 1'b1) begin n_bad++; $display("FAIL single_locked: got %b want 1", uio_out[4]); end
        step(8'h5A, 0, 0, 0);
        n_cmp++; if (uio_out[6] !== 1'b0) begin n_bad++; $display("FAIL single_pulse_lo: got %b want 0", uio_out[6]); end
        send_clean(3);
        bsel = 1'b0; uio_in[3] = 1'b0; #1;
        n_cmp++; if (uo_out !== 8'h01) begin n_bad++; $display("FAIL single_uo_lo: got %h want 01", uo_out); end
        bsel = 1'b1; uio_in[3] = 1'b1; #1;
        n_cmp++; if (uo_out !== 8'h00) begin n_bad++; $display("FAIL single_uo_hi: got %h want 00", uo_out); end
        bsel = 1'b0; uio_in[3] = 1'b0;
        n_cmp++; if (uio_out[4] !== 1'b1) begin n_bad++; $display("FAIL single_still_locked: got %b want 1", uio_out[4]); end
    endtask

    task automatic test_loss_of_lock();
        logic [7:0]  g;
        logic [15:0] c;
        do_reset();
        send_clean(16);
        for (int i = 1; i <= 4; i++) begin
            gen_byte(g);
            step(g ^ 8'h07, 1, 0, 0);
            n_cmp++; if (uio_out[4] !== (i < 4)) begin n_bad++; $display("FAIL lol_locked bad byte %0d: got %b want %b", i, uio_out[4], (i < 4)); end
            n_cmp++; if (uio_out[5] !== (i == 4)) begin n_bad++; $display("FAIL lol_lost bad byte %0d: got %b want %b", i, uio_out[5], (i == 4)); end
        end
        read_cnt(c);
        n_cmp++; if (c !== 16'd12) begin n_bad++; $display("FAIL lol_cnt: got %0d want 12", c); end
        for (int i = 1; i <= 12; i++) begin
            gen_byte(g);
            step(g, 1, 0, 0);
            n_cmp++; if (uio_out[4] !== (i == 12)) begin n_bad++; $display("FAIL relock_locked byte %0d: got %b want %b", i, uio_out[4], (i == 12)); end
            n_cmp++; if (uio_out[5] !== 1'b1) begin n_bad++; $display("FAIL relock_lost byte %0d: got %b want 1", i, uio_out[5]); end
        end
        step(8'h00, 0, 1, 0);
        read_cnt(c);
        n_cmp++; if (uio_out[5] !== 1'b0) begin n_bad++; $display("FAIL clr_lost: got %b want 0", uio_out[5]); end
        n_cmp++; if (c !== 16'd0) begin n_bad++; $display("FAIL clr_cnt_after_lol: got %0d want 0", c); end
    endtask

    task automatic test_all_zero();
        logic [7:0] g;
        do_reset();
        for (int i = 1; i <= 100; i++) begin
            step(8'h00, 1, 0, 0);
            n_cmp++; if (uio_out[4] !== 1'b0) begin n_bad++; $display("FAIL zero_locked byte %0d: got %b want 0", i, uio_out[4]); end
        end
        // A live stream after the zero run must behave like the model's seeding rules.
        for (int i = 1; i <= 30; i++) begin
            gen_byte(g);
            step(g, 1, 0, 0);
            n_cmp++; if (uio_out[4] !== (m_mode == 2)) begin n_bad++; $display("FAIL zero_then_live byte %0d: got %b want %b", i, uio_out[4], (m_mode == 2)); end
        end
    endtask

    task automatic test_saturation();
        logic [7:0]  g;
        logic [15:0] c;
        do_reset();
        send_clean(16);
        for (int i = 1; i <= 65536; i++) begin
            gen_byte(g);
            step(g ^ (8'h01 << $urandom_range(0, 7)), 1, 0, 0);
            if (i == 65534) begin
                read_cnt(c);
                n_cmp++; if (c !== 16'hFFFE) begin n_bad++; $display("FAIL sat_pre_cnt: got %h want fffe", c); end
                n_cmp++; if (uio_out[7] !== 1'b0) begin n_bad++; $display("FAIL sat_pre_flag: got %b want 0", uio_out[7]); end
            end
            if (i == 65535) begin
                n_cmp++; if (uio_out[7] !== 1'b1) begin n_bad++; $display("FAIL sat_edge_flag: got %b want 1", uio_out[7]); end
            end
        end
        read_cnt(c);
        n_cmp++; if (c !== 16'hFFFF) begin n_bad++; $display("FAIL sat_cnt: got %h want ffff", c); end
        n_cmp++; if (uio_out[7] !== 1'b1) begin n_bad++; $display("FAIL sat_flag: got %b want 1", uio_out[7]); end
        n_cmp++; if (uio_out[4] !== 1'b1) begin n_bad++; $display("FAIL sat_locked: got %b want 1", uio_out[4]); end
        gen_byte(g);
        step(g ^ 8'h10, 1, 1, 0);
        read_cnt(c);
        n_cmp++; if (c !== 16'h0000) begin n_bad++; $display("FAIL satclr_cnt: got %h want 0000", c); end
        n_cmp++; if (uio_out[7] !== 1'b0) begin n_bad++; $display("FAIL satclr_flag: got %b want 0", uio_out[7]); end
    endtask

    task automatic test_invert();
        logic [7:0]  g;
        logic [15:0] c;
        bit          want;
        do_reset();
        inv = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            gen_byte(g);
            step(~g, 1, 0, 0);
`ifdef PRBS31_CHK_INVERT_EN
            want = (i >= 12);
`else
            want = 1'b0;
`endif
            n_cmp++; if (uio_out[4] !== want) begin n_bad++; $display("FAIL invert_locked byte %0d: got %b want %b", i, uio_out[4], want); end
        end
        read_cnt(c);
        n_cmp++; if (c !== 16'h0000) begin n_bad++; $display("FAIL invert_cnt: got %h want 0000", c); end
        inv = 1'b0;
        // Without inversion enabled, a complemented byte while locked is 8 bit errors.
        do_reset();
        send_clean(16);
        gen_byte(g);
        step(~g, 1, 0, 0);
        read_cnt(c);
        n_cmp++; if (c !== 16'd8) begin n_bad++; $display("FAIL inverted_byte_cnt: got %0d want 8", c); end
        n_cmp++; if (uio_out[4] !== 1'b1) begin n_bad++; $display("FAIL inverted_byte_locked: got %b want 1", uio_out[4]); end
    endtask

    task automatic test_reset_midstream();
        logic [7:0] g;
        do_reset();
        send_clean(16);
        gen_byte(g);
        step(g ^ 8'h80, 1, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (uio_out !== 8'h00) begin n_bad++; $display("FAIL midreset_uio_out: got %h want 00", uio_out); end
        n_cmp++; if (uo_out !== 8'h00) begin n_bad++; $display("FAIL midreset_uo_out: got %h want 00", uo_out); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        m_reset();
        for (int i = 1; i <= 12; i++) begin
            gen_byte(g);
            step(g, 1, 0, 0);
            n_cmp++; if (uio_out[4] !== (i == 12)) begin n_bad++; $display("FAIL midreset_relock byte %0d: got %b want %b", i, uio_out[4], (i == 12)); end
        end
    endtask

    task automatic test_random();
        logic [7:0]  g;
        logic [7:0]  mask;
        logic [7:0]  exp_uo;
        logic [15:0] me;
        int          mode;
        bit          v, clr, rl;
        do_reset();
        mode = 0;
        for (int i = 0; i < 2000; i++) begin
            if (i % 64 == 0) mode = $urandom_range(0, 2);
            v       = ($urandom_range(0, 3) != 0);
            drv_ena = ($urandom_range(0, 15) != 0);
            bsel    = $urandom_range(0, 1);
            clr     = ($urandom_range(0, 199) == 0);
            rl      = ($urandom_range(0, 299) == 0);
            if (v && drv_ena) begin
                gen_byte(g);
                mask = 8'h00;
                if (mode == 1 && $urandom_range(0, 7) == 0) mask = 8'h01 << $urandom_range(0, 7);
                if (mode == 2 && $urandom_range(0, 1) == 0) mask = 8'($urandom);
                g = g ^ mask;
            end else begin
                g = 8'($urandom);
            end
            step(g, v, clr, rl);
            me     = m_err[15:0];
            exp_uo = bsel ? me[15:8] : me[7:0];
            n_cmp++; if (uio_out[4] !== (m_mode == 2)) begin n_bad++; $display("FAIL rnd_locked cyc %0d: got %b want %b", i, uio_out[4], (m_mode == 2)); end
            n_cmp++; if (uio_out[5] !== m_lost) begin n_bad++; $display("FAIL rnd_lost cyc %0d: got %b want %b", i, uio_out[5], m_lost); end
            n_cmp++; if (uio_out[6] !== m_pulse) begin n_bad++; $display("FAIL rnd_pulse cyc %0d: got %b want %b", i, uio_out[6], m_pulse); end
            n_cmp++; if (uio_out[7] !== m_sat) begin n_bad++; $display("FAIL rnd_sat cyc %0d: got %b want %b", i, uio_out[7], m_sat); end
            n_cmp++; if (uo_out !== exp_uo) begin n_bad++; $display("FAIL rnd_uo cyc %0d: got %h want %h", i, uo_out, exp_uo); end
        end
        drv_ena = 1'b1;
        bsel    = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        m_reset();
        gen_reset();
        test_reset();
        test_clean_lock();
        test_single_error();
        test_loss_of_lock();
        test_all_zero();
        test_invert();
        test_reset_midstream();
        test_random();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tt_um_irrationalanalysis_prbs31_checker.md
# tt_um_irrationalanalysis_prbs31_checker

Byte-parallel PRBS31 (x^31 + x^28 + 1) receiver/checker: the far-end counterpart of the team's PRBS31 pattern generator. It takes one byte of a received PRBS31 stream per valid cycle and self-synchronises its local LFSR to the stream. Once locked, it counts bit errors in a saturating 16-bit counter and reports lock, loss-of-lock and error events on the Tiny Tapeout user pins.

## Interface
Parameters: none.

- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ena  in  1  design enable; when low, `in_valid` is ignored
- ui_in  in  8  received data byte; bit 7 is the earliest bit in time
- uio_in  in  8  [0] in_valid, [1] clr_cnt, [2] relock, [3] byte_sel, [4] invert (only with macro), [7:5] unused
- uo_out  out  8  byte_sel=0: err_cnt[7:0]; byte_sel=1: err_cnt[15:8]; combinational mux of registered count
- uio_out  out  8  [3:0]=0, [4] locked, [5] lost (sticky), [6] err_pulse, [7] cnt_sat
- uio_oe  out  8  constant 8'hF0

## Operation
- State: 31-bit LFSR register `s` and a 2-bit FSM `SEED`, `TRIAL`, `LOCKED`.
- A byte is accepted on a rising edge where `ena && in_valid`. There is no backpressure.
- Prediction: 8 serial steps on `s`, each computing b = s[30]^s[27] and then s = {s[29:0], b}. The first b is predicted bit 7.
- SEED:
  - Each accepted byte updates s <= {s[22:0], byte}.
  - After 4 accepted bytes, go to TRIAL if s != 0. If s == 0, stay in SEED and keep shifting; an all-zero stream never locks.
- TRIAL:
  - Compare each accepted byte to the prediction; s advances by the prediction.
  - 8 consecutive matches: go to LOCKED.
  - Any mismatch: go to SEED, clear the seed byte count and the trial count.
  - err_cnt is not updated in TRIAL.
- LOCKED:
  - Compare each accepted byte to the prediction. Errors = popcount(pred ^ byte), 0..8.
  - err_cnt += errors, saturating at 16'hFFFF; cnt_sat is set when the counter saturates.
  - s always advances by the prediction, never by received data, so bit errors do not propagate.
  - Loss of lock: 4 consecutive accepted bytes each with >=2 bit errors. Then go to SEED, set lost, and clear locked. The 4th byte's errors are still counted.
- relock (level, sampled each edge): go to SEED and clear seed/trial/bad-byte counts. err_cnt and lost are unchanged.
- clr_cnt: clears err_cnt, cnt_sat and lost. Clear wins over a same-edge increment.
- Simultaneous relock and loss-of-lock: lost is set. Simultaneous clr_cnt and loss-of-lock: lost ends at 0.
- err_pulse: high for exactly one cycle after a LOCKED byte with errors >= 1.

## Timing
- Reset values: s=0, FSM=SEED, all counts 0, err_cnt=0, locked=0, lost=0, err_pulse=0, cnt_sat=0, uo_out=0, uio_out=0, uio_oe=8'hF0.
- All status outputs are registered and reflect the byte accepted on edge N from after edge N.
- uo_out follows byte_sel combinationally with zero-cycle latency.
- Minimum lock time: 12 accepted bytes (4 seed + 8 trial). locked rises after the 12th accepting edge.
- Gaps in in_valid stall all state. Back-to-back valid bytes are accepted at full rate.
- Reset asserted mid-stream returns everything to reset values immediately; the first byte after release is seed byte 1.

## Configuration
- `PRBS31_CHK_INVERT_EN` defined:
  - Received bytes are XORed with 8'hFF when uio_in[4]=1, before seeding and comparison.
  - An inverted PRBS31 stream then locks with zero errors.
- Not defined: uio_in[4] is ignored and no inverter logic is built. An inverted stream in LOCKED counts 8 errors per byte.

## Test plan
- Clean lock: reset, then send 64 clean PRBS31 bytes from seed 0x7FFFFFFF, one per cycle. Required: locked=1 after the 12th byte, err_cnt=0, err_pulse never asserts.
- Single error: lock, then flip bit 0 of the 20th byte. Required: err_cnt=1, err_pulse high for 1 cycle, locked stays 1; uo_out=8'h01 with byte_sel=0 and 8'h00 with byte_sel=1.
- Loss of lock: lock, then flip 3 bits in each of 4 consecutive bytes. Required: err_cnt=12, locked=0, lost=1. Continue clean data: locked=1 again 12 bytes later, lost stays 1 until clr_cnt.
- All-zero stream: send 100 bytes of 8'h00 after reset. Required: locked=0 throughout, FSM remains in SEED.
- Saturation and clear: lock, then inject 1 bit error per byte for 65536 bytes. Required: err_cnt=16'hFFFF, cnt_sat=1, locked=1. Pulse clr_cnt in the same cycle as an errored byte: err_cnt=0, cnt_sat=0.
- Invert (with macro): send the inverted stream with uio_in[4]=1. Required: lock in 12 bytes, err_cnt=0. Without the macro, the same stimulus never locks.
